// File: rtl/butterfly_stage.sv
// Radix-2 DIT butterfly (x = a + w'b, y = a - w'b) with a three-stage elastic pipeline,
// optional halving, saturate-or-wrap results and a sticky overflow flag.
module butterfly_stage #(
   parameter int DATA_W  = 32,
   parameter int TW_W    = 16,
   parameter int TW_FRAC = 14,
   parameter int SAT_EN  = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_last,
   input  logic signed [DATA_W-1:0] a_real,
   input  logic signed [DATA_W-1:0] a_imag,
   input  logic signed [DATA_W-1:0] b_real,
   input  logic signed [DATA_W-1:0] b_imag,
   input  logic signed [TW_W-1:0]   w_real,
   input  logic signed [TW_W-1:0]   w_imag,
   input  logic                     inverse,
   input  logic                     scale,
   output logic signed [DATA_W-1:0] x_real,
   output logic signed [DATA_W-1:0] x_imag,
   output logic signed [DATA_W-1:0] y_real,
   output logic signed [DATA_W-1:0] y_imag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   // One extra twiddle bit so that conjugating the most negative value cannot wrap.
   localparam int WE_W  = TW_W + 1;
   localparam int PS_W  = DATA_W + WE_W + 1;
   localparam int P_W   = PS_W - TW_FRAC;
   localparam int SUM_W = ((P_W > DATA_W + 1) ? P_W : DATA_W + 1) + 1;
   localparam logic signed [PS_W-1:0] RND = {{(PS_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};

   function automatic logic in_range(input logic signed [SUM_W-1:0] v);
      logic [SUM_W-DATA_W:0] top;
      top = v[SUM_W-1:DATA_W-1];
      return (&top) | ~(|top);
   endfunction

   function automatic logic [DATA_W-1:0] clamp(input logic signed [SUM_W-1:0] v);
      if ((SAT_EN == 0) || in_range(v)) begin
         return v[DATA_W-1:0];
      end else if (v[SUM_W-1]) begin
         return {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         return {1'b0, {(DATA_W-1){1'b1}}};
      end
   endfunction

   function automatic logic signed [SUM_W-1:0] halve(input logic signed [SUM_W-1:0] v, input logic s);
      if (s) begin
         return v >>> 1;
      end else begin
         return v;
      end
   endfunction

   logic                     advance;
   logic signed [WE_W-1:0]   wr_e, wi_e;
   logic signed [PS_W-1:0]   prod_re, prod_im;
   logic                     v1_r, last1_r, scale1_r;
   logic signed [DATA_W-1:0] ar1_r, ai1_r;
   logic signed [PS_W-1:0]   pr1_r, pi1_r;
   logic signed [PS_W-1:0]   rnd_re, rnd_im;
   logic                     v2_r, last2_r, scale2_r;
   logic signed [DATA_W-1:0] ar2_r, ai2_r;
   logic signed [P_W-1:0]    pr2_r, pi2_r;
   logic signed [SUM_W-1:0]  xr_s, xi_s, yr_s, yi_s;
   logic                     ovf_any;

   assign in_ready = !(out_valid && !out_ready);
   assign advance  = in_ready;

   // Effective twiddle and full-precision complex product.
   always_comb begin
      wr_e = WE_W'(w_real);
      if (inverse) begin
         wi_e = -WE_W'(w_imag);
      end else begin
         wi_e = WE_W'(w_imag);
      end
      prod_re = PS_W'(b_real) * PS_W'(wr_e) - PS_W'(b_imag) * PS_W'(wi_e);
      prod_im = PS_W'(b_real) * PS_W'(wi_e) + PS_W'(b_imag) * PS_W'(wr_e);
   end

   // Stage 1: operands and products.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r <= 1'b0; last1_r <= 1'b0; scale1_r <= 1'b0;
         ar1_r <= '0; ai1_r <= '0; pr1_r <= '0; pi1_r <= '0;
      end else if (advance) begin
         v1_r <= in_valid; last1_r <= in_valid & in_last; scale1_r <= scale;
         ar1_r <= a_real; ai1_r <= a_imag; pr1_r <= prod_re; pi1_r <= prod_im;
      end
   end

   assign rnd_re = pr1_r + RND;
   assign rnd_im = pi1_r + RND;

   // Stage 2: rounded product.
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_r <= 1'b0; last2_r <= 1'b0; scale2_r <= 1'b0;
         ar2_r <= '0; ai2_r <= '0; pr2_r <= '0; pi2_r <= '0;
      end else if (advance) begin
         v2_r <= v1_r; last2_r <= last1_r; scale2_r <= scale1_r;
         ar2_r <= ar1_r; ai2_r <= ai1_r;
         pr2_r <= rnd_re[PS_W-1:TW_FRAC];
         pi2_r <= rnd_im[PS_W-1:TW_FRAC];
      end
   end

   // Sum/difference with optional floor halving.
   always_comb begin
      xr_s = halve(SUM_W'(ar2_r) + SUM_W'(pr2_r), scale2_r);
      xi_s = halve(SUM_W'(ai2_r) + SUM_W'(pi2_r), scale2_r);
      yr_s = halve(SUM_W'(ar2_r) - SUM_W'(pr2_r), scale2_r);
      yi_s = halve(SUM_W'(ai2_r) - SUM_W'(pi2_r), scale2_r);
      ovf_any = !in_range(xr_s) || !in_range(xi_s) || !in_range(yr_s) || !in_range(yi_s);
   end

   // Stage 3: output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0; out_last <= 1'b0;
         x_real <= '0; x_imag <= '0; y_real <= '0; y_imag <= '0;
      end else if (advance) begin
         out_valid <= v2_r; out_last <= last2_r;
         x_real <= clamp(xr_s); x_imag <= clamp(xi_s);
         y_real <= clamp(yr_s); y_imag <= clamp(yi_s);
      end
   end

   // Sticky overflow; a new overflow beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (advance && v2_r && ovf_any) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_butterfly_stage.sv
// Randomized and directed bench for butterfly_stage against a queue-based arithmetic model.
module tb_butterfly_stage;
   localparam int DW = 16;
   localparam int TW = 16;

   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
   logic inverse = 1'b0, scale = 1'b0, out_ready = 1'b1, ovf_clr = 1'b0;
   logic signed [DW-1:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;
   logic signed [TW-1:0] w_real = '0, w_imag = '0;
   logic in_ready, out_valid, out_last, ovf;
   logic signed [DW-1:0] x_real, x_imag, y_real, y_imag;

   butterfly_stage #(.DATA_W(DW), .TW_W(TW), .TW_FRAC(14), .SAT_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
      .w_real(w_real), .w_imag(w_imag), .inverse(inverse), .scale(scale),
      .x_real(x_real), .x_imag(x_imag), .y_real(y_real), .y_imag(y_imag),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .ovf(ovf), .ovf_clr(ovf_clr));

   always #5 clk = ~clk;

   typedef struct {longint xr, xi, yr, yi; bit last; bit ovf;} exp_t;
   exp_t q[$];
   int pass_cnt = 0, total_cnt = 0, hs_cnt = 0, last_cnt = 0;
   bit model_ovf = 1'b0, pending = 1'b0, rst_prev = 1'b1, clr_prev = 1'b0, done = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic bit oor(input longint v);
      return (v > 32767) || (v < -32768);
   endfunction

   function automatic longint lim(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic exp_t model(input longint ar, input longint ai, input longint br,
                                  input longint bi, input longint wr, input longint wi,
                                  input bit inv, input bit scl, input bit last);
      exp_t e;
      longint wie, pr, pim, sxr, sxi, syr, syi;
      wie = inv ? -wi : wi;
      pr  = (br * wr - bi * wie + 8192) >>> 14;
      pim = (br * wie + bi * wr + 8192) >>> 14;
      sxr = ar + pr; sxi = ai + pim; syr = ar - pr; syi = ai - pim;
      if (scl) begin
         sxr = sxr >>> 1; sxi = sxi >>> 1; syr = syr >>> 1; syi = syi >>> 1;
      end
      e.ovf  = oor(sxr) | oor(sxi) | oor(syr) | oor(syi);
      e.xr = lim(sxr); e.xi = lim(sxi); e.yr = lim(syr); e.yi = lim(syi);
      e.last = last;
      return e;
   endfunction

   // Scoreboard: every negedge, compare outputs and record accepted inputs.
   always @(negedge clk) begin
      if (rst_prev) begin
         q.delete(); model_ovf = 1'b0; pending = 1'b0;
         check("rst_out_valid", out_valid, 0);
         check("rst_out_last", out_last, 0);
         check("rst_ovf", ovf, 0);
         check("rst_x_real", x_real, 0);
         check("rst_y_imag", y_imag, 0);
         check("rst_in_ready", in_ready, 1);
      end else begin
         if (clr_prev) model_ovf = 1'b0;
         if (out_valid) begin
            if (q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               if (!pending) model_ovf = model_ovf | q[0].ovf;
               check("x_real", x_real, q[0].xr);
               check("x_imag", x_imag, q[0].xi);
               check("y_real", y_real, q[0].yr);
               check("y_imag", y_imag, q[0].yi);
               check("out_last", out_last, q[0].last);
               if (out_ready) begin
                  void'(q.pop_front());
                  pending = 1'b0; hs_cnt++;
                  if (out_last) last_cnt++;
               end else begin
                  pending = 1'b1;
               end
            end
         end else begin
            check("idle_out_last", out_last, 0);
         end
         check("in_ready", in_ready, !(out_valid && !out_ready));
         check("ovf", ovf, model_ovf);
      end
      rst_prev = rst; clr_prev = ovf_clr;
      if (!rst && in_valid && in_ready)
         q.push_back(model(a_real, a_imag, b_real, b_imag, w_real, w_imag, inverse, scale, in_last));
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drive(input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input bit inv, input bit scl, input bit last);
      int n = 0;
      a_real = 16'(ar); a_imag = 16'(ai); b_real = 16'(br); b_imag = 16'(bi);
      w_real = 16'(wr); w_imag = 16'(wi); inverse = inv; scale = scl; in_last = last;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic dir(input string name, input int ar, input int ai, input int br, input int bi,
                      input int wr, input int wi, input bit inv, input bit scl,
                      input int exr, input int exi, input int eyr, input int eyi, input bit eovf);
      drive(ar, ai, br, bi, wr, wi, inv, scl, 1'b0);
      idle(1);
      check({name, "_latency_early"}, out_valid, 0);
      idle(1);
      check({name, "_out_valid"}, out_valid, 1);
      check({name, "_x_real"}, x_real, exr);
      check({name, "_x_imag"}, x_imag, exi);
      check({name, "_y_real"}, y_real, eyr);
      check({name, "_y_imag"}, y_imag, eyi);
      check({name, "_ovf"}, ovf, eovf);
      idle(2);
   endtask

   function automatic int rnd_data();
      case ($urandom_range(0, 7))
         0: return 32767;
         1: return -32768;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   function automatic int rnd_tw();
      case ($urandom_range(0, 5))
         0: return 16384;
         1: return -16384;
         2: return 0;
         default: return int'($urandom_range(0, 32768)) - 16384;
      endcase
   endfunction

   initial begin
      int hs0, last0;
      idle(3);
      rst = 1'b0;
      idle(1);
      dir("unit_tw", 100, 50, 30, -20, 16384, 0, 1'b0, 1'b0, 130, 30, 70, 70, 1'b0);
      dir("minus_j", 100, 50, 30, -20, 0, -16384, 1'b0, 1'b0, 80, 20, 120, 80, 1'b0);
      dir("inverse", 100, 50, 30, -20, 0, 16384, 1'b1, 1'b0, 80, 20, 120, 80, 1'b0);
      dir("sat_pos", 32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b0, 32767, 0, 0, 0, 1'b1);
      ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0; idle(1);
      check("ovf_cleared", ovf, 0);
      dir("sat_scaled", 32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b1, 32767, 0, 0, 0, 1'b0);
      dir("sat_neg", -32768, 0, 32767, 0, 16384, 0, 1'b0, 1'b0, -1, 0, -32768, 0, 1'b1);
      ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0; idle(1);

      // Ten back-to-back pairs with a five-cycle downstream stall.
      hs0 = hs_cnt; last0 = last_cnt;
      fork
         for (int i = 0; i < 10; i++)
            drive(rnd_data(), rnd_data(), rnd_data(), rnd_data(), rnd_tw(), rnd_tw(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == 9);
         begin
            idle(4);
            out_ready = 1'b0;
            repeat (5) begin @(posedge clk); #2; check("stall_in_ready", in_ready, 0); end
            out_ready = 1'b1;
         end
      join
      idle(8);
      check("bp_pair_count", hs_cnt - hs0, 10);
      check("bp_last_count", last_cnt - last0, 1);

      // Reset with pairs in flight after a sticky overflow.
      drive(32767, 0, 32767, 0, 16384, 0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(i * 10, 5, 7, -3, 16384, 0, 1'b0, 1'b0, i == 2);
      check("pre_rst_ovf", ovf, 1);
      rst = 1'b1; idle(1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_ovf", ovf, 0);
      rst = 1'b0; idle(6);
      check("post_rst_no_stale", out_valid, 0);

      // Randomized traffic with random backpressure and overflow clears.
      fork
         begin
            for (int i = 0; i < 600; i++) begin
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
               drive(rnd_data(), rnd_data(), rnd_data(), rnd_data(), rnd_tw(), rnd_tw(),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7) == 0);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
               ovf_clr = ($urandom_range(0, 15) == 0);
            end
         end
      join
      out_ready = 1'b1; ovf_clr = 1'b0;
      idle(10);
      check("drain_empty", q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
